jk_bank_arbiter: RTL

//   Owns a WIDTH-bit bank of JK flip-flops and shares it between two requesters (A, B).

---
 rtl/jk_bank_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: a WIDTH-bit JK flip-flop bank shared by two requesters.
// The arbiter accepts one command at a time, round-robin between A and B, and applies
// its per-bit J/K pattern for rep+1 consecutive clock edges.
module jk_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_j,
  input  logic [WIDTH-1:0] a_k,
  input  logic [REP_W-1:0] a_rep,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_j,
  input  logic [WIDTH-1:0] b_k,
  input  logic [REP_W-1:0] b_rep,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             owner,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
  localparam logic [WIDTH-1:0] BANK_ZERO = {WIDTH{1'b0}};

  // JK characteristic equation applied bitwise: Q+ = J & ~Q | ~K & Q.
  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] j,
                                                input logic [WIDTH-1:0] k);
    jk_next = (j & ~cur) | (~k & cur);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;      // 0: prefer A, 1: prefer B
  logic             done_q, done_d;
  logic             grant_a_s, grant_b_s;
  logic             can_grant_s;

  // Grant decode: only in IDLE, never during clr or reset; rr pointer breaks ties.
  always_comb begin
    can_grant_s = (state_q == ST_IDLE) && !clr && !reset;
    grant_a_s   = can_grant_s && a_valid && (!b_valid || !rr_q);
    grant_b_s   = can_grant_s && b_valid && (!a_valid || rr_q);
  end

  // Next-state logic: clr first, then accept in IDLE or apply in BUSY.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    j_d        = j_q;
    k_d        = k_q;
    rep_left_d = rep_left_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    done_d     = 1'b0;
    if (clr) begin
      // Abort whatever is running; owner and rr pointer keep their history.
      bank_d     = BANK_ZERO;
      state_d    = ST_IDLE;
      rep_left_d = REP_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_a_s) begin
            j_d        = a_j;
            k_d        = a_k;
            rep_left_d = a_rep;
            owner_d    = 1'b0;
            rr_d       = 1'b1;
            state_d    = ST_BUSY;
          end else if (grant_b_s) begin
            j_d        = b_j;
            k_d        = b_k;
            rep_left_d = b_rep;
            owner_d    = 1'b1;
            rr_d       = 1'b0;
            state_d    = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          bank_d = jk_next(bank_q, j_q, k_q);
          // Count down to zero then stop; zero is the last apply, so no underflow.
          if (rep_left_q == REP_ZERO) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            rep_left_d = rep_left_q - REP_ONE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          rep_left_d = REP_ZERO;
        end
      endcase
    end
  end

  // State registers; async reset abandons any command and zeroes the bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bank_q     <= BANK_ZERO;
      j_q        <= BANK_ZERO;
      k_q        <= BANK_ZERO;
      rep_left_q <= REP_ZERO;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      j_q        <= j_d;
      k_q        <= k_d;
      rep_left_q <= rep_left_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      done_q     <= done_d;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;
  assign q       = bank_q;
  assign busy    = (state_q == ST_BUSY);
  assign owner   = owner_q;
  assign done    = done_q;

endmodule
